// File: rtl/bist_pkg.sv
// Shared types, default polynomials/seeds and the seed helper for the BIST harness.
// The optional golden-signature comparator is enabled by defining BIST_CMP_EN.
`timescale 1ns/1ps
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [7:0]  DEF_LFSR_POLY = 8'hB8;
  localparam logic [7:0]  DEF_LFSR_SEED = 8'h01;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

  // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
  function automatic logic [31:0] sanitize_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'd1 : seed;
  endfunction

endpackage

// File: rtl/bist_harness_if.sv
// Bundle of run-control, core-side and result signals between the BIST harness and its wrapper.
// GOLDEN and PASS exist only when BIST_CMP_EN is defined.
`timescale 1ns/1ps
interface bist_harness_if #(
  parameter int PI_W   = 3,
  parameter int PO_W   = 6,
  parameter int MISR_W = 16,
  parameter int CNT_W  = 16
);
  // Handshake: START is a level request with no ready; it is acted on only at a
  // clock edge where the harness is in IDLE or DONE, and NPAT is captured at that
  // same edge. While BUSY is high START is ignored; DONE is the completion flag.
  logic              START;
  logic [CNT_W-1:0]  NPAT;
  logic [PO_W-1:0]   PO;
  logic [PI_W-1:0]   PI;
  logic              BUSY;
  logic              DONE;
  logic [MISR_W-1:0] SIG;
`ifdef BIST_CMP_EN
  logic [MISR_W-1:0] GOLDEN;
  logic              PASS;

  modport master (output START, NPAT, PO, GOLDEN, input PI, BUSY, DONE, SIG, PASS);
  modport slave  (input START, NPAT, PO, GOLDEN, output PI, BUSY, DONE, SIG, PASS);
`else
  modport master (output START, NPAT, PO, input PI, BUSY, DONE, SIG);
  modport slave  (input START, NPAT, PO, output PI, BUSY, DONE, SIG);
`endif
endinterface

// File: rtl/bist_shift_reg.sv
// Left-shifting LFSR/MISR cell: tap-mask feedback into bit 0, parallel XOR input,
// synchronous load and step enable. nxt is the stepped value of the current state.
`timescale 1ns/1ps
module bist_shift_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] POLY    = '0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    nxt  = {sr_q[W-2:0], ^(sr_q & POLY)} ^ din;
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (en) begin
      sr_d = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/bist_harness.sv
// BIST harness: PRPG drives core PIs, MISR compacts core POs over NPAT patterns.
// Define BIST_CMP_EN to add the GOLDEN comparator and PASS output.
`timescale 1ns/1ps
module bist_harness
  import bist_pkg::*;
#(
  parameter int                PI_W      = 3,
  parameter int                PO_W      = 6,
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = DEF_MISR_POLY,
  parameter int                CNT_W     = 16,
  parameter int                LAT       = 0
) (
  input  logic         CK,
  input  logic         RST,
  bist_harness_if.slave bus,
  output bist_state_e  dbg_state
);

  localparam int                FL_W   = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [FL_W-1:0]   LAT_V  = FL_W'(LAT);
  localparam logic [FL_W-1:0]   LAT_M1 = FL_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [LFSR_W-1:0] SEED   = LFSR_W'(sanitize_seed(32'(LFSR_SEED)));

  bist_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  npat_q, npat_d;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic [FL_W-1:0]   w_q, w_d;
  logic [PI_W-1:0]   pi_q, pi_d;

  logic              lfsr_load, lfsr_en;
  logic              misr_load, misr_en;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic [MISR_W-1:0] misr_q, misr_nxt;
  logic              start_ok;
  logic              unused_bits;

  assign start_ok = bus.START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // w_q saturates at LAT: the first LAT busy cycles see no valid core response yet.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    npat_d    = npat_q;
    fl_d      = fl_q;
    w_d       = w_q;
    pi_d      = '0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          npat_d    = bus.NPAT;
          cnt_d     = '0;
          fl_d      = '0;
          w_d       = '0;
          lfsr_load = 1'b1;
          misr_load = 1'b1;
          if (bus.NPAT == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            pi_d    = SEED[PI_W-1:0];
          end
        end
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        misr_en = (w_q == LAT_V);
        if (w_q != LAT_V) w_d = w_q + FL_W'(1);
        if (cnt_q == npat_q - CNT_W'(1)) begin
          state_d = (LAT == 0) ? ST_DONE : ST_FLUSH;
          fl_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          pi_d  = lfsr_nxt[PI_W-1:0];
        end
      end
      ST_FLUSH: begin
        misr_en = (w_q == LAT_V);
        if (w_q != LAT_V) w_d = w_q + FL_W'(1);
        if (fl_q == LAT_M1) begin
          state_d = ST_DONE;
        end else begin
          fl_d = fl_q + FL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      npat_q  <= '0;
      fl_q    <= '0;
      w_q     <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      fl_q    <= fl_d;
      w_q     <= w_d;
      pi_q    <= pi_d;
    end
  end

  bist_shift_reg #(
    .W       (LFSR_W),
    .POLY    (LFSR_POLY),
    .RST_VAL (SEED)
  ) u_prpg (
    .clk      (CK),
    .rst      (RST),
    .load     (lfsr_load),
    .load_val (SEED),
    .en       (lfsr_en),
    .din      ({LFSR_W{1'b0}}),
    .q        (lfsr_q),
    .nxt      (lfsr_nxt)
  );

  bist_shift_reg #(
    .W       (MISR_W),
    .POLY    (MISR_POLY),
    .RST_VAL ({MISR_W{1'b0}})
  ) u_misr (
    .clk      (CK),
    .rst      (RST),
    .load     (misr_load),
    .load_val ({MISR_W{1'b0}}),
    .en       (misr_en),
    .din      (MISR_W'(bus.PO)),
    .q        (misr_q),
    .nxt      (misr_nxt)
  );

  // PI comes from the PRPG look-ahead, so its state word and the MISR look-ahead are not read here.
  assign unused_bits = ^{lfsr_q, lfsr_nxt, misr_nxt};

  assign bus.PI    = pi_q;
  assign bus.BUSY  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign bus.DONE  = (state_q == ST_DONE);
  assign bus.SIG   = misr_q;
  assign dbg_state = state_q;
`ifdef BIST_CMP_EN
  assign bus.PASS  = (state_q == ST_DONE) && (misr_q == bus.GOLDEN);
`endif

endmodule

// File: tb/tb_bist_harness.sv
// Directed bench for bist_harness: one instance with LAT=0, one with LAT=2.
// PASS/GOLDEN checks are compiled in when BIST_CMP_EN is defined.
`timescale 1ns/1ps
module tb_bist_harness;
  import bist_pkg::*;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  bist_harness_if bus0 ();
  bist_harness_if bus2 ();
  bist_state_e st0, st2;

  bist_harness #(.LAT(0)) u_dut0 (.CK(CK), .RST(RST), .bus(bus0), .dbg_state(st0));
  bist_harness #(.LAT(2)) u_dut2 (.CK(CK), .RST(RST), .bus(bus2), .dbg_state(st2));

  int n_vec  = 0;
  int n_fail = 0;
  int comp2  = 0;

  always @(posedge CK) if (u_dut2.misr_en) comp2 <= comp2 + 1;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [5:0] po);
    return {m[14:0], ^(m & 16'hB400)} ^ {10'b0, po};
  endfunction

  // Starts a run on the LAT=0 instance and waits (bounded) for DONE.
  task automatic run0(input logic [15:0] npat, output int busy_cyc, output int wait_cyc,
                      output bit done_seen);
    busy_cyc  = 0;
    wait_cyc  = 0;
    done_seen = 1'b0;
    bus0.NPAT  = npat;
    bus0.START = 1'b1;
    @(negedge CK);
    bus0.START = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus0.DONE === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (bus0.BUSY === 1'b1) busy_cyc++;
      wait_cyc++;
      @(negedge CK);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CK);
    n_vec++; if (bus0.PI !== 3'b000) begin n_fail++; $display("FAIL reset_pi: got %b want 000", bus0.PI); end
    n_vec++; if (bus0.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.BUSY); end
    n_vec++; if (bus0.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus0.DONE); end
    n_vec++; if (bus0.SIG !== 16'h0000) begin n_fail++; $display("FAIL reset_sig: got %h want 0000", bus0.SIG); end
    n_vec++; if (st0 !== ST_IDLE || st2 !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d/%0d want 0/0", st0, st2); end
`ifdef BIST_CMP_EN
    n_vec++; if (bus0.PASS !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", bus0.PASS); end
`endif
    RST = 1'b0;
    @(negedge CK);
  endtask

  task automatic test_pi_sequence;
    logic [2:0] exp_pi [5];
    exp_pi = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001};
    bus0.PO    = 6'h00;
    bus0.NPAT  = 16'd5;
    bus0.START = 1'b1;
    @(negedge CK);
    bus0.START = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (bus0.PI !== exp_pi[k] || bus0.BUSY !== 1'b1 || bus0.DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL pi_seq[%0d]: got pi=%b busy=%b done=%b want pi=%b busy=1 done=0",
                 k, bus0.PI, bus0.BUSY, bus0.DONE, exp_pi[k]);
      end
      @(negedge CK);
    end
    n_vec++;
    if (bus0.DONE !== 1'b1 || bus0.BUSY !== 1'b0 || bus0.PI !== 3'b000) begin
      n_fail++;
      $display("FAIL pi_seq_done: got done=%b busy=%b pi=%b want done=1 busy=0 pi=000",
               bus0.DONE, bus0.BUSY, bus0.PI);
    end
  endtask

  task automatic test_signature;
    int busy_cyc, wait_cyc;
    bit done_seen;
    bus0.PO = 6'h01;
    run0(16'd2, busy_cyc, wait_cyc, done_seen);
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL sig_timeout: done not seen within bound"); end
    n_vec++; if (busy_cyc != 2) begin n_fail++; $display("FAIL sig_busy: got %0d want 2", busy_cyc); end
    n_vec++; if (bus0.SIG !== 16'h0003) begin n_fail++; $display("FAIL sig_value: got %h want 0003", bus0.SIG); end
`ifdef BIST_CMP_EN
    bus0.GOLDEN = 16'h0003;
    #1;
    n_vec++; if (bus0.PASS !== 1'b1) begin n_fail++; $display("FAIL pass_match: got %b want 1", bus0.PASS); end
    bus0.GOLDEN = 16'h0004;
    #1;
    n_vec++; if (bus0.PASS !== 1'b0) begin n_fail++; $display("FAIL pass_mismatch: got %b want 0", bus0.PASS); end
`endif
  endtask

  task automatic test_zero_npat;
    int busy_cyc, wait_cyc;
    bit done_seen;
    bus0.PO = 6'h15;
    run0(16'd0, busy_cyc, wait_cyc, done_seen);
    n_vec++; if (!done_seen || wait_cyc != 0) begin n_fail++; $display("FAIL zero_done: seen=%0d after %0d cycles want seen=1 after 0", done_seen, wait_cyc); end
    n_vec++; if (busy_cyc != 0) begin n_fail++; $display("FAIL zero_busy: got %0d want 0", busy_cyc); end
    n_vec++; if (bus0.SIG !== 16'h0000) begin n_fail++; $display("FAIL zero_sig: got %h want 0000", bus0.SIG); end
  endtask

  task automatic test_start_ignored;
    int busy_cyc = 0;
    bit done_seen = 1'b0;
    bus0.PO    = 6'h01;
    bus0.NPAT  = 16'd4;
    bus0.START = 1'b1;
    @(negedge CK);
    bus0.START = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus0.DONE === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (bus0.BUSY === 1'b1) busy_cyc++;
      bus0.START = (c == 1 || c == 2);
      bus0.NPAT  = (c == 1 || c == 2) ? 16'd9 : 16'd4;
      @(negedge CK);
    end
    bus0.START = 1'b0;
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL ign_timeout: done not seen within bound"); end
    n_vec++; if (busy_cyc != 4) begin n_fail++; $display("FAIL ign_busy: got %0d want 4", busy_cyc); end
    n_vec++; if (bus0.SIG !== 16'h000F) begin n_fail++; $display("FAIL ign_sig: got %h want 000f", bus0.SIG); end
    bus0.PO = 6'h3F;
    repeat (3) @(negedge CK);
    n_vec++;
    if (bus0.SIG !== 16'h000F || bus0.DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: got sig=%h done=%b want sig=000f done=1", bus0.SIG, bus0.DONE);
    end
  endtask

  task automatic test_latency;
    int busy_cyc = 0;
    int comp_base;
    bit done_seen = 1'b0;
    logic [2:0] pi_seen [8];
    for (int k = 0; k < 8; k++) pi_seen[k] = 3'b111;
    bus2.PO    = 6'h00;
    bus2.NPAT  = 16'd4;
    comp_base  = comp2;
    bus2.START = 1'b1;
    @(negedge CK);
    bus2.START = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus2.DONE === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (bus2.BUSY === 1'b1) begin
        if (busy_cyc < 8) pi_seen[busy_cyc] = bus2.PI;
        busy_cyc++;
      end
      @(negedge CK);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL lat_timeout: done not seen within bound"); end
    n_vec++; if (busy_cyc != 6) begin n_fail++; $display("FAIL lat_busy: got %0d want 6", busy_cyc); end
    n_vec++; if (comp2 - comp_base != 4) begin n_fail++; $display("FAIL lat_compactions: got %0d want 4", comp2 - comp_base); end
    n_vec++; if (bus2.SIG !== 16'h0000) begin n_fail++; $display("FAIL lat_sig: got %h want 0000", bus2.SIG); end
    n_vec++; if (pi_seen[0] !== 3'b001) begin n_fail++; $display("FAIL lat_pi_first: got %b want 001", pi_seen[0]); end
    n_vec++;
    if (pi_seen[4] !== 3'b000 || pi_seen[5] !== 3'b000) begin
      n_fail++;
      $display("FAIL lat_pi_flush: got %b %b want 000 000", pi_seen[4], pi_seen[5]);
    end
  endtask

  task automatic test_long_run;
    int busy_cyc = 0;
    bit done_seen = 1'b0;
    logic [7:0]  lfsr_m = 8'h01;
    logic [15:0] sig_m  = 16'h0000;
    logic [2:0]  pi_m;
    for (int k = 0; k < 20; k++) sig_m = misr_next(sig_m, 6'h3F);
    bus2.PO    = 6'h3F;
    bus2.NPAT  = 16'd20;
    bus2.START = 1'b1;
    @(negedge CK);
    bus2.START = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus2.DONE === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (bus2.BUSY === 1'b1) begin
        pi_m = (busy_cyc < 20) ? lfsr_m[2:0] : 3'b000;
        n_vec++;
        if (bus2.PI !== pi_m) begin
          n_fail++;
          $display("FAIL long_pi[%0d]: got %b want %b", busy_cyc, bus2.PI, pi_m);
        end
        lfsr_m = lfsr_next(lfsr_m);
        busy_cyc++;
      end
      @(negedge CK);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL long_timeout: done not seen within bound"); end
    n_vec++; if (busy_cyc != 22) begin n_fail++; $display("FAIL long_busy: got %0d want 22", busy_cyc); end
    n_vec++; if (bus2.SIG !== sig_m) begin n_fail++; $display("FAIL long_sig: got %h want %h", bus2.SIG, sig_m); end
  endtask

  task automatic test_reset_mid_run;
    int busy_cyc, wait_cyc;
    bit done_seen;
    logic [2:0] exp_pi [3];
    exp_pi = '{3'b001, 3'b010, 3'b100};
    bus0.PO    = 6'h2A;
    bus0.NPAT  = 16'd100;
    bus0.START = 1'b1;
    @(negedge CK);
    bus0.START = 1'b0;
    repeat (10) @(negedge CK);
    n_vec++; if (bus0.BUSY !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus0.BUSY); end
    #2 RST = 1'b1;
    #1;
    n_vec++; if (bus0.PI !== 3'b000) begin n_fail++; $display("FAIL rst_pi: got %b want 000", bus0.PI); end
    n_vec++; if (bus0.BUSY !== 1'b0 || bus0.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got busy=%b done=%b want 0 0", bus0.BUSY, bus0.DONE); end
    n_vec++; if (bus0.SIG !== 16'h0000) begin n_fail++; $display("FAIL rst_sig: got %h want 0000", bus0.SIG); end
    n_vec++; if (st0 !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", st0); end
    @(negedge CK);
    RST = 1'b0;
    @(negedge CK);
    bus0.NPAT  = 16'd5;
    bus0.START = 1'b1;
    @(negedge CK);
    bus0.START = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus0.PI !== exp_pi[k]) begin
        n_fail++;
        $display("FAIL rerun_pi[%0d]: got %b want %b", k, bus0.PI, exp_pi[k]);
      end
      @(negedge CK);
    end
    bus0.NPAT = 16'd0;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus0.DONE === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      @(negedge CK);
    end
    n_vec++; if (!done_seen) begin n_fail++; $display("FAIL rerun_timeout: done not seen within bound"); end
    busy_cyc = 0;
    wait_cyc = 0;
  endtask

  initial begin
    bus0.START = 1'b0; bus0.NPAT = '0; bus0.PO = '0;
    bus2.START = 1'b0; bus2.NPAT = '0; bus2.PO = '0;
`ifdef BIST_CMP_EN
    bus0.GOLDEN = '0;
    bus2.GOLDEN = '0;
`endif
    test_reset;
    test_pi_sequence;
    test_signature;
    test_zero_npat;
    test_start_ignored;
    test_latency;
    test_long_run;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
